// File: rtl/pipe_hazard_unit.sv
// Hazard control for the 5-stage RV32 pipeline: forwarding selects, load-use
// stalls, branch flushes, multi-cycle memory freezes and saturating counters.

module hz_fwd_lane #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        fwd,
  output logic              byp
);
  logic mem_hit, wb_hit;

  always_comb begin
    mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs);
    wb_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_rs);
    fwd     = mem_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);
    byp     = wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs);
  end
endmodule

module pipe_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              mem_access,
  input  logic              branch_taken,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              cnt_clr,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              id_byp_a,
  output logic              id_byp_b,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              flush_ifid,
  output logic              bubble_idex,
  output logic              flush_exmem,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  freeze_cnt
);
  localparam int NUM_OPS = 2;
  localparam logic [3:0] WC_INIT = 4'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  typedef enum logic {S_RUN, S_WAIT} state_e;

  logic [NUM_OPS-1:0][REG_AW-1:0] ex_rs_v, id_rs_v;
  logic [NUM_OPS-1:0][1:0]        fwd_v;
  logic [NUM_OPS-1:0]             byp_v;

  assign ex_rs_v = {ex_rs2, ex_rs1};
  assign id_rs_v = {id_rs2, id_rs1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    hz_fwd_lane #(.REG_AW(REG_AW)) u_lane (
      .ex_rs       (ex_rs_v[g]),
      .id_rs       (id_rs_v[g]),
      .mem_rd      (mem_rd),
      .mem_regwrite(mem_regwrite),
      .wb_rd       (wb_rd),
      .wb_regwrite (wb_regwrite),
      .fwd         (fwd_v[g]),
      .byp         (byp_v[g])
    );
  end

  state_e     state_q, state_d;
  logic [3:0] wc_q, wc_d;
  logic       freeze, lu, do_flush, do_stall;

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    freeze  = 1'b0;
    case (state_q)
      S_RUN: if ((MEM_LAT > 1) && mem_access) begin
        freeze  = 1'b1;
        state_d = S_WAIT;
        wc_d    = WC_INIT;
      end
      S_WAIT: if (wc_q != 4'd0) begin
        freeze = 1'b1;
        wc_d   = wc_q - 4'd1;
      end else begin
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      wc_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
    end
  end

  always_comb begin
    lu = ex_memread && (ex_rd != '0) &&
         ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
    do_flush = branch_taken && !freeze;
    do_stall = lu && !branch_taken && !freeze;
  end

  // Everything is held at its pass-through value while reset is low.
  always_comb begin
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    id_byp_a    = 1'b0;
    id_byp_b    = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    flush_exmem = 1'b0;
    if (reset) begin
      fwd_a    = fwd_v[0];
      fwd_b    = fwd_v[1];
      id_byp_a = byp_v[0];
      id_byp_b = byp_v[1];
      if (freeze) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end else if (do_flush) begin
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
        flush_exmem = 1'b1;
      end else if (do_stall) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        bubble_idex = 1'b1;
      end
    end
  end

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d, flush_cnt_d, freeze_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      flush_cnt_d  = '0;
      freeze_cnt_d = '0;
    end else begin
      if (do_stall && (stall_cnt_q  != '1)) stall_cnt_d  = stall_cnt_q  + 1'b1;
      if (do_flush && (flush_cnt_q  != '1)) flush_cnt_d  = flush_cnt_q  + 1'b1;
      if (freeze   && (freeze_cnt_q != '1)) freeze_cnt_d = freeze_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: three instances (MEM_LAT=4, MEM_LAT=1,
// CNT_W=4) share one stimulus stream; expected values are hand-computed.

module tb_pipe_hazard_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, mem_regwrite, mem_access;
  logic       branch_taken, wb_regwrite, cnt_clr;

  logic [1:0]  fwd_a, fwd_b, l_fwd_a, l_fwd_b, s_fwd_a, s_fwd_b;
  logic        id_byp_a, id_byp_b, l_byp_a, l_byp_b, s_byp_a, s_byp_b;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        l_pc_en, l_ifid_en, l_idex_en, l_exmem_en, l_memwb_en;
  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        flush_ifid, bubble_idex, flush_exmem;
  logic        l_flush_ifid, l_bubble_idex, l_flush_exmem;
  logic        s_flush_ifid, s_bubble_idex, s_flush_exmem;
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;
  logic [15:0] l_stall_cnt, l_flush_cnt, l_freeze_cnt;
  logic [3:0]  s_stall_cnt, s_flush_cnt, s_freeze_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_AW(5), .MEM_LAT(4), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_access(mem_access), .branch_taken(branch_taken), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .cnt_clr(cnt_clr), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .id_byp_a(id_byp_a), .id_byp_b(id_byp_b), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en), .flush_ifid(flush_ifid),
    .bubble_idex(bubble_idex), .flush_exmem(flush_exmem), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt));

  pipe_hazard_unit #(.REG_AW(5), .MEM_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_access(mem_access), .branch_taken(branch_taken), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .cnt_clr(cnt_clr), .fwd_a(l_fwd_a), .fwd_b(l_fwd_b),
    .id_byp_a(l_byp_a), .id_byp_b(l_byp_b), .pc_en(l_pc_en), .ifid_en(l_ifid_en),
    .idex_en(l_idex_en), .exmem_en(l_exmem_en), .memwb_en(l_memwb_en),
    .flush_ifid(l_flush_ifid), .bubble_idex(l_bubble_idex), .flush_exmem(l_flush_exmem),
    .stall_cnt(l_stall_cnt), .flush_cnt(l_flush_cnt), .freeze_cnt(l_freeze_cnt));

  pipe_hazard_unit #(.REG_AW(5), .MEM_LAT(4), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_access(mem_access), .branch_taken(branch_taken), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .cnt_clr(cnt_clr), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .id_byp_a(s_byp_a), .id_byp_b(s_byp_b), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
    .idex_en(s_idex_en), .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
    .flush_ifid(s_flush_ifid), .bubble_idex(s_bubble_idex), .flush_exmem(s_flush_exmem),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .freeze_cnt(s_freeze_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; mem_access = 0; branch_taken = 0;
    wb_rd = 0; wb_regwrite = 0; cnt_clr = 0;
  endtask

  function automatic logic [4:0] ens();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  endfunction

  function automatic logic [2:0] fls();
    return {flush_ifid, bubble_idex, flush_exmem};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs held at pass-through even with hazards on the inputs
    idle();
    reset = 1'b0;
    ex_rs1 = 5; mem_rd = 5; mem_regwrite = 1; mem_access = 1; id_rs1 = 5;
    wb_rd = 5; wb_regwrite = 1;
    #1;
    chk("rst_ens", ens(), 5'b11111);
    chk("rst_fls", fls(), 3'b000);
    chk("rst_fwd_a", fwd_a, 2'b00);
    chk("rst_byp_a", id_byp_a, 1'b0);
    chk("rst_cnts", {stall_cnt, flush_cnt, freeze_cnt}, 48'h0);
    @(negedge clk); idle();
    @(negedge clk); reset = 1'b1;

    // Forwarding priority and x0 exclusion
    @(negedge clk);
    ex_rs1 = 5; mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1; id_rs1 = 5;
    #1;
    chk("fwd_mem", fwd_a, 2'b10);
    chk("fwd_b_none", fwd_b, 2'b00);
    chk("byp_a", id_byp_a, 1'b1);
    mem_regwrite = 0; ex_rs2 = 5; #1;
    chk("fwd_wb", fwd_a, 2'b01);
    chk("fwd_b_wb", fwd_b, 2'b01);
    ex_rs1 = 0; #1;
    chk("fwd_x0", fwd_a, 2'b00);
    wb_rd = 0; id_rs1 = 0; #1;
    chk("byp_x0", id_byp_a, 1'b0);

    // Load-use stall
    @(negedge clk); idle();
    ex_memread = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; #1;
    chk("lu_ens", ens(), 5'b00111);
    chk("lu_fls", fls(), 3'b010);
    @(negedge clk); idle(); #1;
    chk("lu_after_ens", ens(), 5'b11111);
    chk("lu_cnt", stall_cnt, 16'd1);
    ex_memread = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 0; #1;
    chk("nolu_ens", ens(), 5'b11111);
    chk("nolu_fls", fls(), 3'b000);
    @(negedge clk); idle(); #1;
    chk("nolu_cnt", stall_cnt, 16'd1);

    // Branch flush, then branch coinciding with load-use
    branch_taken = 1; #1;
    chk("br_fls", fls(), 3'b111);
    chk("br_ens", ens(), 5'b11111);
    @(negedge clk); idle(); #1;
    chk("br_cnt", flush_cnt, 16'd1);
    branch_taken = 1; ex_memread = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; #1;
    chk("brlu_ens", ens(), 5'b11111);
    chk("brlu_fls", fls(), 3'b111);
    @(negedge clk); idle(); #1;
    chk("brlu_flush_cnt", flush_cnt, 16'd2);
    chk("brlu_stall_cnt", stall_cnt, 16'd1);

    // Freeze (MEM_LAT=4): three frozen cycles; a branch held during it flushes at release
    mem_access = 1; #1;
    chk("frz0_ens", ens(), 5'b00000);
    chk("lat1_ens", {l_pc_en, l_ifid_en, l_idex_en, l_exmem_en, l_memwb_en}, 5'b11111);
    @(negedge clk); branch_taken = 1; #1;
    chk("frz1_ens", ens(), 5'b00000);
    chk("frz1_fls", fls(), 3'b000);
    @(negedge clk); #1;
    chk("frz2_ens", ens(), 5'b00000);
    @(negedge clk); #1;
    chk("rel_ens", ens(), 5'b11111);
    chk("rel_fls", fls(), 3'b111);
    @(negedge clk); idle(); #1;
    chk("frz_cnt", freeze_cnt, 16'd3);
    chk("frz_flush_cnt", flush_cnt, 16'd3);
    chk("lat1_frz_cnt", l_freeze_cnt, 16'd0);

    // Reset asserted mid-WAIT
    mem_access = 1;
    @(negedge clk); idle(); reset = 1'b0; #1;
    chk("rstw_ens", ens(), 5'b11111);
    chk("rstw_cnt", freeze_cnt, 16'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    chk("rstw_post_ens", ens(), 5'b11111);
    chk("rstw_post_cnt", {stall_cnt, flush_cnt, freeze_cnt}, 48'h0);

    // Saturation (CNT_W=4) and clear overriding an increment
    ex_memread = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    repeat (20) @(negedge clk);
    #1;
    chk("sat_cnt", s_stall_cnt, 4'hf);
    chk("wide_cnt", stall_cnt, 16'd20);
    cnt_clr = 1;
    @(negedge clk); #1;
    chk("clr_sat", s_stall_cnt, 4'h0);
    chk("clr_wide", stall_cnt, 16'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
